// File: rtl/adc_fmt_pkg.sv
// Shared constants and state encoding for the ADC-to-millivolt BCD formatter.
package adc_fmt_pkg;

    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam int         MV_MAX       = 9999;
    localparam int         BCD_BIN_W    = 14;
    localparam int         BCD_OUT_W    = 16;
    // Product width is ADC_W plus this; FULL_SCALE_MV fits in 15 bits.
    localparam int         PROD_EXTRA_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SAT,
        ST_BCD,
        ST_HOLD
    } state_e;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 14-bit double-dabble: load on start_i, 14 shift cycles, done_o pulses once.
module bin2bcd_seq
    import adc_fmt_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [BCD_BIN_W-1:0] bin_i,
    output logic                 done_o,
    output logic [BCD_OUT_W-1:0] bcd_o
);

    localparam int SH_W = BCD_OUT_W + BCD_BIN_W;

    logic [SH_W-1:0] sh_q;
    logic [SH_W-1:0] adj_d;
    logic [3:0]      cnt_q;
    logic            run_q;
    logic            done_q;

    // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
    always_comb begin
        adj_d = sh_q;
        for (int i = 0; i < BCD_OUT_W / 4; i++) begin
            if (adj_d[BCD_BIN_W + 4*i +: 4] >= 4'd5) begin
                adj_d[BCD_BIN_W + 4*i +: 4] = adj_d[BCD_BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            sh_q   <= {{BCD_OUT_W{1'b0}}, bin_i};
            cnt_q  <= '0;
            run_q  <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            sh_q <= {adj_d[SH_W-2:0], 1'b0};
            if (cnt_q == 4'(BCD_BIN_W - 1)) begin
                run_q  <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o = done_q;
    assign bcd_o  = sh_q[SH_W-1:BCD_BIN_W];

endmodule

// File: rtl/adc_volt_fmt.sv
// Converts a two's-complement ADC sample to a signed BCD millivolt word for the UART
// reporter: shift-add scaling, saturation, double-dabble, then a held ack strobe.
module adc_volt_fmt
    import adc_fmt_pkg::*;
#(
    parameter int ADC_W         = 12,
    parameter int FULL_SCALE_MV = 5000,
    parameter int ACK_HOLD      = 1024
) (
    input  logic             clk50,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] sample,
    input  logic             sample_valid,
    output logic [27:0]      rdata,
    output logic             ack,
    output logic             busy,
    output logic             overrun
);

    localparam int               PROD_W = ADC_W + PROD_EXTRA_W;
    localparam int               HOLD_W = $clog2(ACK_HOLD + 1);
    localparam logic [PROD_W-1:0] FS_P  = PROD_W'(FULL_SCALE_MV);
    localparam logic [27:0]      RDATA_RST = {ASCII_PLUS, 20'h00000};

    state_e                 state_q;
    logic                   sign_q;
    logic [ADC_W-1:0]       mplier_q;
    logic [PROD_W-1:0]      mcand_q;
    logic [PROD_W-1:0]      prod_q;
    logic [4:0]             bit_cnt_q;
    logic [BCD_BIN_W-1:0]   mv_q;
    logic [HOLD_W-1:0]      hold_cnt_q;
    logic [27:0]            rdata_q;
    logic                   ack_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic [ADC_W-1:0]       mag_d;
    logic [PROD_W-1:0]      scaled_d;
    logic [BCD_BIN_W-1:0]   mv_d;
    logic                   bcd_start;
    logic                   bcd_done;
    logic [BCD_OUT_W-1:0]   bcd_val;

    // ADC_W-bit magnitude keeps -2^(ADC_W-1) representable.
    assign mag_d    = sample[ADC_W-1] ? (~sample + 1'b1) : sample;
    assign scaled_d = prod_q >> (ADC_W - 1);
    assign mv_d     = (scaled_d > PROD_W'(MV_MAX)) ? BCD_BIN_W'(MV_MAX)
                                                   : scaled_d[BCD_BIN_W-1:0];
    assign bcd_start = (state_q == ST_SAT);

    bin2bcd_seq u_bin2bcd (
        .clk_i   (clk50),
        .rst_ni  (reset_n),
        .start_i (bcd_start),
        .bin_i   (mv_d),
        .done_o  (bcd_done),
        .bcd_o   (bcd_val)
    );

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sign_q     <= 1'b0;
            mplier_q   <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            bit_cnt_q  <= '0;
            mv_q       <= '0;
            hold_cnt_q <= '0;
            rdata_q    <= RDATA_RST;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= sample_valid && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (sample_valid) begin
                        sign_q    <= sample[ADC_W-1];
                        mplier_q  <= mag_d;
                        mcand_q   <= FS_P;
                        prod_q    <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mplier_q[0]) begin
                        prod_q <= prod_q + mcand_q;
                    end
                    mplier_q <= mplier_q >> 1;
                    mcand_q  <= mcand_q << 1;
                    if (bit_cnt_q == 5'(ADC_W - 1)) begin
                        state_q <= ST_SAT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                    end
                end
                ST_SAT: begin
                    mv_q    <= mv_d;
                    state_q <= ST_BCD;
                end
                ST_BCD: begin
                    if (bcd_done) begin
                        // Negative zero is reported as '+'.
                        rdata_q    <= {(sign_q && (mv_q != '0)) ? ASCII_MINUS : ASCII_PLUS,
                                       4'h0, bcd_val};
                        ack_q      <= 1'b1;
                        hold_cnt_q <= '0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_W'(ACK_HOLD - 1)) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata   = rdata_q;
    assign ack     = ack_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_adc_volt_fmt.sv
// Directed bench for adc_volt_fmt: nominal, low and saturating full-scale instances share stimulus.
module tb_adc_volt_fmt;

    logic        clk50 = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;

    logic [27:0] rdata, rdata_lo, rdata_hi;
    logic        ack, ack_lo, ack_hi;
    logic        busy, busy_lo, busy_hi;
    logic        overrun, overrun_lo, overrun_hi;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 clk50 = ~clk50;

    adc_volt_fmt #(.ADC_W(12), .FULL_SCALE_MV(5000), .ACK_HOLD(1024)) dut (
        .clk50(clk50), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .rdata(rdata), .ack(ack), .busy(busy), .overrun(overrun));

    adc_volt_fmt #(.ADC_W(12), .FULL_SCALE_MV(1), .ACK_HOLD(1024)) dut_lo (
        .clk50(clk50), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .rdata(rdata_lo), .ack(ack_lo), .busy(busy_lo), .overrun(overrun_lo));

    adc_volt_fmt #(.ADC_W(12), .FULL_SCALE_MV(20000), .ACK_HOLD(1024)) dut_hi (
        .clk50(clk50), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .rdata(rdata_hi), .ack(ack_hi), .busy(busy_hi), .overrun(overrun_hi));

    task automatic send(input logic [11:0] code);
        @(posedge clk50); #1;
        sample = code;
        sample_valid = 1'b1;
        @(posedge clk50); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_ack_high(output int n);
        n = 0;
        while (ack !== 1'b1 && n < 200) begin
            @(posedge clk50); #1;
            n++;
        end
    endtask

    task automatic wait_ack_low(output int m);
        m = 0;
        while (ack === 1'b1 && m < 3000) begin
            @(posedge clk50); #1;
            m++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk50);
        #1;
        total_cnt++; if (rdata !== 28'h2B00000) $display("FAIL reset_rdata got=%h exp=%h", rdata, 28'h2B00000); else pass_cnt++;
        total_cnt++; if (ack !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_pos_full();
        int n, m;
        send(12'h7FF);
        total_cnt++; if (busy !== 1'b1) $display("FAIL pos_busy_rise got=%b exp=1", busy); else pass_cnt++;
        wait_ack_high(n);
        total_cnt++; if (n != 28) $display("FAIL pos_latency got=%0d exp=28", n); else pass_cnt++;
        total_cnt++; if (rdata !== 28'h2B04997) $display("FAIL pos_rdata got=%h exp=%h", rdata, 28'h2B04997); else pass_cnt++;
        total_cnt++; if (rdata_hi !== 28'h2B09999) $display("FAIL sat_rdata got=%h exp=%h", rdata_hi, 28'h2B09999); else pass_cnt++;
        total_cnt++; if (rdata_lo !== 28'h2B00000) $display("FAIL lo_pos_rdata got=%h exp=%h", rdata_lo, 28'h2B00000); else pass_cnt++;
        wait_ack_low(m);
        total_cnt++; if (m != 1024) $display("FAIL ack_width got=%0d exp=1024", m); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL busy_fall got=%b exp=0", busy); else pass_cnt++;
    endtask

    task automatic test_negative();
        int n, m;
        send(12'h800);
        wait_ack_high(n);
        total_cnt++; if (n != 28) $display("FAIL neg_latency got=%0d exp=28", n); else pass_cnt++;
        total_cnt++; if (rdata !== 28'h2D05000) $display("FAIL neg_min_rdata got=%h exp=%h", rdata, 28'h2D05000); else pass_cnt++;
        wait_ack_low(m);
        send(12'hFFF);
        wait_ack_high(n);
        total_cnt++; if (rdata !== 28'h2D00002) $display("FAIL neg_one_rdata got=%h exp=%h", rdata, 28'h2D00002); else pass_cnt++;
        total_cnt++; if (rdata_lo !== 28'h2B00000) $display("FAIL neg_zero_sign got=%h exp=%h", rdata_lo, 28'h2B00000); else pass_cnt++;
        wait_ack_low(m);
    endtask

    task automatic test_zero();
        int n, m;
        send(12'h000);
        wait_ack_high(n);
        total_cnt++; if (rdata !== 28'h2B00000) $display("FAIL zero_rdata got=%h exp=%h", rdata, 28'h2B00000); else pass_cnt++;
        total_cnt++; if (rdata_lo !== 28'h2B00000) $display("FAIL lo_zero_rdata got=%h exp=%h", rdata_lo, 28'h2B00000); else pass_cnt++;
        wait_ack_low(m);
    endtask

    task automatic test_overrun();
        int n, m;
        send(12'h7FF);
        repeat (4) @(posedge clk50);
        #1;
        sample = 12'h800;
        sample_valid = 1'b1;
        @(posedge clk50); #1;
        sample_valid = 1'b0;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL overrun_pulse got=%b exp=1", overrun); else pass_cnt++;
        @(posedge clk50); #1;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL overrun_single got=%b exp=0", overrun); else pass_cnt++;
        wait_ack_high(n);
        total_cnt++; if (n != 22) $display("FAIL overrun_latency got=%0d exp=22", n); else pass_cnt++;
        total_cnt++; if (rdata !== 28'h2B04997) $display("FAIL overrun_rdata got=%h exp=%h", rdata, 28'h2B04997); else pass_cnt++;
        wait_ack_low(m);
    endtask

    task automatic test_hold_exit();
        int n, m;
        send(12'h800);
        wait_ack_high(n);
        repeat (1023) @(posedge clk50);
        #1;
        total_cnt++; if (ack !== 1'b1) $display("FAIL hold_last_ack got=%b exp=1", ack); else pass_cnt++;
        sample = 12'hFFF;
        sample_valid = 1'b1;
        @(posedge clk50); #1;
        total_cnt++; if (ack !== 1'b0) $display("FAIL hold_exit_ack got=%b exp=0", ack); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL hold_exit_drop got=%b exp=1", overrun); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL hold_exit_busy got=%b exp=0", busy); else pass_cnt++;
        @(posedge clk50); #1;
        sample_valid = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL next_accept_busy got=%b exp=1", busy); else pass_cnt++;
        wait_ack_high(n);
        total_cnt++; if (n != 28) $display("FAIL next_accept_latency got=%0d exp=28", n); else pass_cnt++;
        total_cnt++; if (rdata !== 28'h2D00002) $display("FAIL next_accept_rdata got=%h exp=%h", rdata, 28'h2D00002); else pass_cnt++;
        wait_ack_low(m);
    endtask

    task automatic test_reset_mid();
        int n, m;
        send(12'h7FF);
        repeat (20) @(posedge clk50);
        #1;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (rdata !== 28'h2B00000) $display("FAIL midreset_rdata got=%h exp=%h", rdata, 28'h2B00000); else pass_cnt++;
        total_cnt++; if (ack !== 1'b0) $display("FAIL midreset_ack got=%b exp=0", ack); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy); else pass_cnt++;
        repeat (2) @(posedge clk50);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk50);
        #1;
        total_cnt++; if (ack !== 1'b0 || rdata !== 28'h2B00000) $display("FAIL midreset_no_partial ack=%b rdata=%h exp ack=0 rdata=%h", ack, rdata, 28'h2B00000); else pass_cnt++;
        send(12'hFFF);
        wait_ack_high(n);
        total_cnt++; if (n != 28) $display("FAIL postreset_latency got=%0d exp=28", n); else pass_cnt++;
        total_cnt++; if (rdata !== 28'h2D00002) $display("FAIL postreset_rdata got=%h exp=%h", rdata, 28'h2D00002); else pass_cnt++;
        wait_ack_low(m);
    endtask

    initial begin
        test_reset();
        test_pos_full();
        test_negative();
        test_zero();
        test_overrun();
        test_hold_exit();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
